// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline interlock controller for the five-stage MIPS core.
//
// Each cycle it decides whether the instruction in D may advance into E, or
// whether F and D freeze while a bubble is loaded into E. Two hazard sources:
//   * register read-after-write, comparing Tuse in D against Tnew in E and M;
//   * the multi-cycle mult/div unit, whose busy window is a 4-bit countdown.
//
// Build option: define PIPE_CTRL_STATS_EN to build the saturating stall
// statistics counters. Without it both statistics ports read 0 and no
// counter flops exist. Stall behaviour does not depend on the option.
//
// Reset is synchronous and active-low on the port named 'reset'.

module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,   // busy cycles after mult/multu starts in E (1..15)
  parameter int unsigned DIV_CYCLES  = 10   // busy cycles after div/divu starts in E (1..15)
) (
  input  logic        clk,
  input  logic        reset,

  // Operand usage of the instruction in D
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,

  // Producer in E
  input  logic [4:0]  a3_E,
  input  logic        we_E,
  input  logic [1:0]  tnew_E,

  // Producer in M
  input  logic [4:0]  a3_M,
  input  logic        we_M,
  input  logic [1:0]  tnew_M,

  // Mult/div interaction
  input  logic [1:0]  md_op_E,
  input  logic        md_use_D,

  // Pipeline control
  output logic        en_F,
  output logic        en_D,
  output logic        flush_E,
  output logic        md_busy,

  // Statistics
  output logic [31:0] data_stall_cnt,
  output logic [31:0] md_stall_cnt
);

  // Operand is "not used" when its Tuse carries this value.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Encoding of md_op_E; 2'b11 is reserved and behaves like MD_NONE.
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // --------------------------------------------------------------------------
  // Register hazard detection
  // --------------------------------------------------------------------------
  logic haz_rs_E;
  logic haz_rt_E;
  logic haz_rs_M;
  logic haz_rt_M;
  logic data_stall;

  // A hazard exists when D reads a non-zero register that an older
  // instruction will write, and D needs it before that result exists.
  always_comb begin
    haz_rs_E = (tuse_rs_D != TUSE_NONE) && (rs_D != 5'd0) && we_E &&
               (rs_D == a3_E) && (tuse_rs_D < tnew_E);
    haz_rt_E = (tuse_rt_D != TUSE_NONE) && (rt_D != 5'd0) && we_E &&
               (rt_D == a3_E) && (tuse_rt_D < tnew_E);
    haz_rs_M = (tuse_rs_D != TUSE_NONE) && (rs_D != 5'd0) && we_M &&
               (rs_D == a3_M) && (tuse_rs_D < tnew_M);
    haz_rt_M = (tuse_rt_D != TUSE_NONE) && (rt_D != 5'd0) && we_M &&
               (rt_D == a3_M) && (tuse_rt_D < tnew_M);
    data_stall = haz_rs_E | haz_rt_E | haz_rs_M | haz_rt_M;
  end

  // --------------------------------------------------------------------------
  // Mult/div busy countdown
  // --------------------------------------------------------------------------
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       md_start;
  logic       md_active;
  logic       md_stall;

  // A start is only honoured with the unit idle; a start while busy cannot
  // happen legally (D is frozen) and is ignored rather than restarting.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d     = cnt_q;
    md_start  = (md_op_E == MD_MULT) || (md_op_E == MD_DIV);
    md_active = (cnt_q != 4'd0);
    if (md_start && !md_active) begin
      cnt_d = (md_op_E == MD_MULT) ? MULT_LOAD : DIV_LOAD;
    end else if (md_active) begin
      cnt_d = cnt_q - 4'd1;
    end
    // A mult/div-related instruction in D must wait while the unit is busy
    // or while a new operation is starting in E this very cycle.
    md_stall = md_use_D && (md_active || md_start);
  end

  // Countdown register; reset abandons any busy window.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline control outputs (purely combinational, forced safe in reset)
  // --------------------------------------------------------------------------
  logic stall;

  // While reset is low F and D are held and E receives bubbles.
  always_comb begin
    stall   = data_stall | md_stall;
    en_F    = reset & ~stall;
    en_D    = reset & ~stall;
    flush_E = ~reset | stall;
    md_busy = reset & md_active;
  end

  // --------------------------------------------------------------------------
  // Stall statistics
  // --------------------------------------------------------------------------
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] data_stall_cnt_q;
  logic [31:0] data_stall_cnt_d;
  logic [31:0] md_stall_cnt_q;
  logic [31:0] md_stall_cnt_d;

  // Saturating counts; a cycle with both hazards is charged to data only.
  always_comb begin
    data_stall_cnt_d = data_stall_cnt_q;
    md_stall_cnt_d   = md_stall_cnt_q;
    if (data_stall) begin
      if (data_stall_cnt_q != 32'hFFFF_FFFF) begin
        data_stall_cnt_d = data_stall_cnt_q + 32'd1;
      end
    end else if (md_stall) begin
      if (md_stall_cnt_q != 32'hFFFF_FFFF) begin
        md_stall_cnt_d = md_stall_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_stall_cnt_q <= 32'd0;
      md_stall_cnt_q   <= 32'd0;
    end else begin
      data_stall_cnt_q <= data_stall_cnt_d;
      md_stall_cnt_q   <= md_stall_cnt_d;
    end
  end

  assign data_stall_cnt = data_stall_cnt_q;
  assign md_stall_cnt   = md_stall_cnt_q;
`else
  assign data_stall_cnt = 32'd0;
  assign md_stall_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-indexed reference model.
// Build with +define+PIPE_CTRL_STATS_EN to expect live statistics counters.

module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, a3_E, a3_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M, md_op_E;
  logic        we_E, we_M, md_use_D;
  logic        en_F, en_D, flush_E, md_busy;
  logic [31:0] data_stall_cnt, md_stall_cnt;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_E(a3_E), .we_E(we_E), .tnew_E(tnew_E),
    .a3_M(a3_M), .we_M(we_M), .tnew_M(tnew_M),
    .md_op_E(md_op_E), .md_use_D(md_use_D),
    .en_F(en_F), .en_D(en_D), .flush_E(flush_E), .md_busy(md_busy),
    .data_stall_cnt(data_stall_cnt), .md_stall_cnt(md_stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: absolute cycle index, last busy cycle, stall tallies.
  int     cyc        = 0;
  int     busy_last  = -1;
  longint dcnt       = 0;
  longint mcnt       = 0;
  bit     stats_known = 0;
  logic   obs_en_D, obs_busy;

  function automatic bit reads_early(input logic [4:0] r, input logic [1:0] tuse,
                                     input logic [4:0] dst, input logic we,
                                     input logic [1:0] tnew);
    if (tuse == 2'd3 || r == 5'd0 || !we || r != dst) return 0;
    return int'(tuse) < int'(tnew);
  endfunction

  // One clock: check outputs mid-cycle, then advance the model to the edge.
  task automatic run_cycle();
    bit busy, dh, start, mh, st;
    longint dexp, mexp;
    @(negedge clk);
    busy  = (cyc <= busy_last);
    dh    = reads_early(rs_D, tuse_rs_D, a3_E, we_E, tnew_E) |
            reads_early(rt_D, tuse_rt_D, a3_E, we_E, tnew_E) |
            reads_early(rs_D, tuse_rs_D, a3_M, we_M, tnew_M) |
            reads_early(rt_D, tuse_rt_D, a3_M, we_M, tnew_M);
    start = (md_op_E == 2'b01) || (md_op_E == 2'b10);
    mh    = md_use_D && (busy || start);
    st    = dh || mh;
    if (!reset) begin
      check("en_F_rst",    32'(en_F),    32'd0);
      check("en_D_rst",    32'(en_D),    32'd0);
      check("flush_E_rst", 32'(flush_E), 32'd1);
      check("md_busy_rst", 32'(md_busy), 32'd0);
    end else begin
      check("en_F",    32'(en_F),    32'(!st));
      check("en_D",    32'(en_D),    32'(!st));
      check("flush_E", 32'(flush_E), 32'(st));
      check("md_busy", 32'(md_busy), 32'(busy));
    end
`ifdef PIPE_CTRL_STATS_EN
    dexp = dcnt; mexp = mcnt;
`else
    dexp = 0; mexp = 0;
`endif
    if (stats_known) begin
      check("data_stall_cnt", data_stall_cnt, 32'(dexp));
      check("md_stall_cnt",   md_stall_cnt,   32'(mexp));
    end
    obs_en_D = en_D;
    obs_busy = md_busy;
    if (!reset) begin
      busy_last   = cyc;       // nothing busy from the next cycle on
      dcnt        = 0;
      mcnt        = 0;
      stats_known = 1;
    end else begin
      if (start && !busy)
        busy_last = cyc + ((md_op_E == 2'b01) ? MULT_N : DIV_N);
      if (dh)      dcnt++;
      else if (mh) mcnt++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_D = 0; rt_D = 0; tuse_rs_D = 3; tuse_rt_D = 3;
    a3_E = 0; we_E = 0; tnew_E = 0;
    a3_M = 0; we_M = 0; tnew_M = 0;
    md_op_E = 0; md_use_D = 0;
  endtask

  // Register hazard via E on rs, no mult/div involvement.
  task automatic data_haz();
    idle();
    a3_E = 5'd8; we_E = 1; tnew_E = 2; rs_D = 5'd8; tuse_rs_D = 1;
  endtask

  task automatic rand_inputs(input bit allow_start);
    rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
    a3_E = 5'($urandom_range(0, 3)); a3_M = 5'($urandom_range(0, 3));
    tuse_rs_D = 2'($urandom); tuse_rt_D = 2'($urandom);
    tnew_E = 2'($urandom); tnew_M = 2'($urandom);
    we_E = 1'($urandom); we_M = 1'($urandom);
    md_use_D = 1'($urandom);
    md_op_E = allow_start ? 2'($urandom) : 2'(2'b11 & {1'b1, 1'($urandom)} & 2'b11);
    if (!allow_start && (md_op_E == 2'b01 || md_op_E == 2'b10)) md_op_E = 2'b00;
  endtask

  initial begin
    // Reset held two cycles with a random hazard present.
    reset = 0;
    rand_inputs(1);
    data_haz();
    md_use_D = 1; md_op_E = 2'b01;
    run_cycle();
    run_cycle();
    reset = 1; idle();
    run_cycle();
    check("rel_en_D", 32'(obs_en_D), 32'd1);

    // Load-use: stall once, then forwarded from M.
    data_haz();
    run_cycle();
    check("loaduse_stall", 32'(obs_en_D), 32'd0);
    idle(); a3_M = 5'd8; we_M = 1; tnew_M = 1; rs_D = 5'd8; tuse_rs_D = 1;
    run_cycle();
    check("loaduse_go", 32'(obs_en_D), 32'd1);

    // $0 and unused operands never interlock.
    idle(); rs_D = 0; a3_E = 0; we_E = 1; tnew_E = 2; tuse_rs_D = 0;
    run_cycle();
    check("zero_reg", 32'(obs_en_D), 32'd1);
    idle(); rt_D = 5'd9; tuse_rt_D = 3; a3_E = 5'd9; we_E = 1; tnew_E = 2;
    run_cycle();
    check("unused_rt", 32'(obs_en_D), 32'd1);

    // Mult then mflo held in D: stall cycles 0..5, advance in 6.
    idle(); md_op_E = 2'b01; md_use_D = 1;
    run_cycle();
    md_op_E = 2'b00;
    for (int i = 1; i <= MULT_N; i++) run_cycle();
    check("mult_last_stall", 32'(obs_en_D), 32'd0);
    run_cycle();
    check("mult_adv", 32'(obs_en_D), 32'd1);
    check("mult_idle", 32'(obs_busy), 32'd0);

    // Div then mflo: stall cycles 0..10.
    idle(); md_op_E = 2'b10; md_use_D = 1;
    run_cycle();
    md_op_E = 2'b00;
    for (int i = 1; i <= DIV_N; i++) run_cycle();
    check("div_last_stall", 32'(obs_en_D), 32'd0);
    run_cycle();
    check("div_adv", 32'(obs_en_D), 32'd1);

    // Reset in cycle 4 of a div abandons the busy window.
    idle(); md_op_E = 2'b10;
    run_cycle();
    md_op_E = 2'b00;
    for (int i = 1; i < 4; i++) run_cycle();
    reset = 0;
    run_cycle();
    reset = 1; md_use_D = 1;
    run_cycle();
    check("rstdiv_busy", 32'(obs_busy), 32'd0);
    check("rstdiv_go",   32'(obs_en_D), 32'd1);

    // Statistics: 3 data-only, 6 md-only, 2 both, starting from reset.
    idle(); reset = 0;
    run_cycle();
    reset = 1;
    for (int i = 0; i < 3; i++) begin data_haz(); run_cycle(); end
    idle(); md_op_E = 2'b10; md_use_D = 1;
    run_cycle();
    md_op_E = 2'b00;
    for (int i = 0; i < 5; i++) run_cycle();
    for (int i = 0; i < 2; i++) begin data_haz(); md_use_D = 1; run_cycle(); end
    idle();
    run_cycle();
`ifdef PIPE_CTRL_STATS_EN
    check("stats_data", data_stall_cnt, 32'd5);
    check("stats_md",   md_stall_cnt,   32'd6);
`else
    check("stats_data_off", data_stall_cnt, 32'd0);
    check("stats_md_off",   md_stall_cnt,   32'd0);
`endif
    for (int i = 0; i < DIV_N; i++) run_cycle();

    // Randomized traffic; starts only issued with the unit idle.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      rand_inputs(cyc > busy_last);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
